// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
//   Shared constants and types for the button input path: button bit indices
//   within the 7-bit pad bus, default timing constants, and the per-button
//   debounce state encoding.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package sudoku_pkg;

    // Bit positions in raw_buttons / pending: [6:0] = right, left, down, up, b, a, start
    localparam int unsigned BTN_START   = 0;
    localparam int unsigned BTN_A       = 1;
    localparam int unsigned BTN_B       = 2;
    localparam int unsigned BTN_UP      = 3;
    localparam int unsigned BTN_DOWN    = 4;
    localparam int unsigned BTN_LEFT    = 5;
    localparam int unsigned BTN_RIGHT   = 6;
    localparam int unsigned NUM_BUTTONS = 7;

    // Default timing, in clk cycles
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } db_state_t;

    // Only the direction pad auto-repeats.
    function automatic bit is_direction(input int unsigned idx);
        return (idx >= BTN_UP) && (idx <= BTN_RIGHT);
    endfunction

    function automatic int unsigned max_of3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   One button: synchronizer chain, debounce FSM and optional auto-repeat.
//   Ports:
//     clk        - sole clock, rising edge
//     reset      - asynchronous, active-low
//     raw        - asynchronous active-high pad level
//     press_req  - registered one-cycle press request (initial press and repeats)
//     held       - high while the debounced level is high (HELD/REPEAT/RELEASE_DB)
// -----------------------------------------------------------------------------
module button_debouncer
    import sudoku_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press_req,
    output logic held
);

    localparam int unsigned CNT_MAX = max_of3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

    // Counters hold "samples already seen", so a transition fires when the
    // count has reached target-1 and the current sample still agrees.
    localparam logic [CW-1:0] DB_TGT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_TGT = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RR_TGT = CW'((REPEAT_RATE  > 0) ? REPEAT_RATE  - 1 : 0);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    db_state_t              state;
    logic [CW-1:0]          db_cnt;
    logic [CW-1:0]          rp_cnt;
    logic                   was_repeat;

    assign synced = sync[SYNC_STAGES-1];
    assign held   = (state == HELD) || (state == REPEAT) || (state == RELEASE_DB);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync       <= '0;
            state      <= IDLE;
            db_cnt     <= '0;
            rp_cnt     <= '0;
            was_repeat <= 1'b0;
            press_req  <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], raw};
            press_req <= 1'b0;

            case (state)
                // The sample that leaves IDLE is the first stable-high sample.
                IDLE: begin
                    if (synced) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            state      <= HELD;
                            press_req  <= 1'b1;
                            rp_cnt     <= '0;
                            was_repeat <= 1'b0;
                        end else begin
                            state  <= PRESS_DB;
                            db_cnt <= CW'(1);
                        end
                    end
                end

                PRESS_DB: begin
                    if (!synced) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_TGT) begin
                        state      <= HELD;
                        press_req  <= 1'b1;
                        db_cnt     <= '0;
                        rp_cnt     <= '0;
                        was_repeat <= 1'b0;
                    end else begin
                        db_cnt <= sat_inc(db_cnt);
                    end
                end

                HELD: begin
                    if (!synced) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                        end else begin
                            state      <= RELEASE_DB;
                            db_cnt     <= CW'(1);
                            was_repeat <= 1'b0;
                        end
                    end else if (REPEAT_EN) begin
                        if (rp_cnt >= RD_TGT) begin
                            state     <= REPEAT;
                            press_req <= 1'b1;
                            rp_cnt    <= '0;
                        end else begin
                            rp_cnt <= sat_inc(rp_cnt);
                        end
                    end
                end

                REPEAT: begin
                    if (!synced) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                        end else begin
                            state      <= RELEASE_DB;
                            db_cnt     <= CW'(1);
                            was_repeat <= 1'b1;
                        end
                    end else if (rp_cnt >= RR_TGT) begin
                        press_req <= 1'b1;
                        rp_cnt    <= '0;
                    end else begin
                        rp_cnt <= sat_inc(rp_cnt);
                    end
                end

                // rp_cnt is left untouched here so a release glitch does not
                // restart the hold/repeat timing.
                RELEASE_DB: begin
                    if (synced) begin
                        state  <= was_repeat ? REPEAT : HELD;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_TGT) begin
                        state      <= IDLE;
                        db_cnt     <= '0;
                        rp_cnt     <= '0;
                        was_repeat <= 1'b0;
                    end else begin
                        db_cnt <= sat_inc(db_cnt);
                    end
                end

                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                    rp_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions the seven game pad inputs into single-cycle press pulses.
//   Each button is synchronized and debounced by its own button_debouncer;
//   press requests are merged into a pending register and issued one per
//   cycle in fixed priority start > a > b > up > down > left > right.
//   Ports:
//     clk           - sole clock, rising edge
//     reset         - asynchronous, active-low
//     raw_buttons   - [6:0] = right, left, down, up, b, a, start pad levels
//     *_button      - registered one-cycle press pulses
//     any_held      - high while any debounced button level is high
// -----------------------------------------------------------------------------
module button_conditioner
    import sudoku_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] raw_buttons,
    output logic       start_button,
    output logic       a_button,
    output logic       b_button,
    output logic       up_button,
    output logic       down_button,
    output logic       left_button,
    output logic       right_button,
    output logic       any_held
);

    logic [NUM_BUTTONS-1:0] req;
    logic [NUM_BUTTONS-1:0] held;
    logic [NUM_BUTTONS-1:0] pending;
    logic [NUM_BUTTONS-1:0] grant;
    logic [NUM_BUTTONS-1:0] pulse_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (is_direction(i))
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw_buttons[i]),
            .press_req(req[i]),
            .held     (held[i])
        );
    end

    // Lowest set bit wins; bit 0 (start) is highest priority.
    always_comb begin
        grant = pending & (~pending + 7'd1);
    end

    // A request for an already-pending bit simply ORs in, so it never queues twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= grant;
            pending <= (pending & ~grant) | req;
        end
    end

    assign start_button = pulse_q[BTN_START];
    assign a_button     = pulse_q[BTN_A];
    assign b_button     = pulse_q[BTN_B];
    assign up_button    = pulse_q[BTN_UP];
    assign down_button  = pulse_q[BTN_DOWN];
    assign left_button  = pulse_q[BTN_LEFT];
    assign right_button = pulse_q[BTN_RIGHT];
    assign any_held     = |held;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3. Stimulus pushes
//   expected pulses (edge stamp + 7-bit vector) into a queue; a monitor pops
//   and compares whenever any pulse output is high.
//   Edge k of a scenario is the k-th rising edge after its raw inputs are set;
//   outputs after edge k are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] raw_buttons;
    logic       start_button, a_button, b_button, up_button;
    logic       down_button, left_button, right_button, any_held;
    logic [6:0] pulses;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int base = 0;

    typedef struct {
        int         stamp;
        logic [6:0] vec;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [6:0] M_START = 7'b0000001;
    localparam logic [6:0] M_A     = 7'b0000010;
    localparam logic [6:0] M_UP    = 7'b0001000;
    localparam logic [6:0] M_DOWN  = 7'b0010000;
    localparam logic [6:0] M_LEFT  = 7'b0100000;

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (3)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .raw_buttons (raw_buttons),
        .start_button(start_button),
        .a_button    (a_button),
        .b_button    (b_button),
        .up_button   (up_button),
        .down_button (down_button),
        .left_button (left_button),
        .right_button(right_button),
        .any_held    (any_held)
    );

    assign pulses = {right_button, left_button, down_button, up_button,
                     b_button, a_button, start_button};

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every cycle with a pulse is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (pulses != 7'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got %b at stamp %0d, required no pulse",
                         pulses, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.stamp != edge_cnt || e.vec != pulses) begin
                    bad++;
                    $display("FAIL pulse: got %b at stamp %0d, required %b at stamp %0d",
                             pulses, edge_cnt, e.vec, e.stamp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic at_edge(input int k);
        while (edge_cnt < base + 1 + k) @(negedge clk);
    endtask

    task automatic set_at(input int k, input logic [6:0] v);
        if (k > 0) at_edge(k - 1);
        raw_buttons = v;
    endtask

    task automatic begin_scenario(input logic [6:0] v);
        base = edge_cnt;
        raw_buttons = v;
    endtask

    task automatic expect_pulse(input int k, input logic [6:0] v);
        exp_t e;
        e.stamp = base + 1 + k;
        e.vec   = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic idle_and_flush(input string name);
        raw_buttons = '0;
        repeat (14) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d pulses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_idle_held"}, {6'b0, any_held}, 7'b0);
    endtask

    initial begin
        reset       = 1'b0;
        raw_buttons = 7'h7F;
        @(negedge clk);

        // Reset state with all pads driven high
        repeat (3) @(negedge clk);
        check("reset_pulses", pulses, 7'b0);
        check("reset_any_held", {6'b0, any_held}, 7'b0);
        raw_buttons = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_any_held", {6'b0, any_held}, 7'b0);

        // Start held, with a 2-cycle release glitch mid-hold
        begin_scenario(M_START);
        expect_pulse(7, M_START);
        at_edge(4);  check("start_held_pre", {6'b0, any_held}, 7'b0);
        at_edge(5);  check("start_held_rise", {6'b0, any_held}, 7'b1);
        set_at(10, 7'b0);
        set_at(12, M_START);
        at_edge(13); check("start_glitch_held", {6'b0, any_held}, 7'b1);
        at_edge(16); check("start_glitch_back", {6'b0, any_held}, 7'b1);
        set_at(20, 7'b0);
        at_edge(24); check("start_release_pre", {6'b0, any_held}, 7'b1);
        at_edge(25); check("start_release_fall", {6'b0, any_held}, 7'b0);
        idle_and_flush("start_hold");

        // Short press glitch on a: no pulse, no held
        begin_scenario(M_A);
        set_at(3, 7'b0);
        at_edge(4);  check("a_glitch_held4", {6'b0, any_held}, 7'b0);
        at_edge(8);  check("a_glitch_held8", {6'b0, any_held}, 7'b0);
        idle_and_flush("a_glitch");

        // Glitch immediately followed by a real press: counter must restart
        begin_scenario(M_A);
        set_at(3, 7'b0);
        set_at(5, M_A);
        expect_pulse(12, M_A);
        at_edge(9);  check("a_repress_pre", {6'b0, any_held}, 7'b0);
        at_edge(10); check("a_repress_held", {6'b0, any_held}, 7'b1);
        set_at(15, 7'b0);
        idle_and_flush("a_repress");

        // Up held 30 cycles: initial pulse then auto-repeat
        begin_scenario(M_UP);
        expect_pulse(7, M_UP);
        for (int k = 15; k <= 33; k += 3) expect_pulse(k, M_UP);
        set_at(30, 7'b0);
        idle_and_flush("up_repeat");

        // a held 30 cycles: exactly one pulse
        begin_scenario(M_A);
        expect_pulse(7, M_A);
        set_at(30, 7'b0);
        idle_and_flush("a_no_repeat");

        // start, a and down together: serialized by priority
        begin_scenario(M_START | M_A | M_DOWN);
        expect_pulse(7, M_START);
        expect_pulse(8, M_A);
        expect_pulse(9, M_DOWN);
        set_at(10, 7'b0);
        idle_and_flush("priority");

        // Reset during left debounce, button still held afterwards
        begin_scenario(M_LEFT);
        at_edge(4);  reset = 1'b0;
        at_edge(6);  check("left_in_reset_held", {6'b0, any_held}, 7'b0);
                     check("left_in_reset_pulse", pulses, 7'b0);
        at_edge(7);  reset = 1'b1;
        expect_pulse(15, M_LEFT);
        at_edge(12); check("left_redb_pre", {6'b0, any_held}, 7'b0);
        at_edge(13); check("left_redb_held", {6'b0, any_held}, 7'b1);
        set_at(16, 7'b0);
        idle_and_flush("left_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per raw input, minimum 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000: consecutive stable synchronized samples needed to accept a level change, minimum 1.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000: cycles a direction button is held after its first pulse before auto-repeat starts.
REQ-004 Parameter REPEAT_RATE, default 10_000_000: cycles between auto-repeat pulses.
REQ-005 Port clk  input  1  sole clock; all state on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port raw_buttons  input  7  asynchronous active-high pad levels; bit order [6:0] = right, left, down, up, b, a, start.
REQ-008 Ports start_button, a_button, b_button, up_button, down_button, left_button, right_button  output  1 each  single-cycle registered press pulses to the game FSM.
REQ-009 Port any_held  output  1  high while any debounced button level is high.

Function
REQ-010 Each raw bit SHALL pass through SYNC_STAGES flops before any other logic.
REQ-011 Each button SHALL have its own FSM with states IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB.
REQ-012 IDLE -> PRESS_DB on synchronized high; PRESS_DB counts stable-high samples, returns to IDLE on any low sample, and moves to HELD on reaching DEBOUNCE_CYCLES while raising one press request.
REQ-013 HELD -> RELEASE_DB on synchronized low; RELEASE_DB -> IDLE after DEBOUNCE_CYCLES stable-low samples, back to the prior held state on any high sample.
REQ-014 For up, down, left and right only: HELD -> REPEAT after REPEAT_DELAY cycles in HELD; REPEAT raises one press request every REPEAT_RATE cycles while held. start, a and b never repeat.
REQ-015 A clean press held stable SHALL produce its pulse exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after the first clk edge that samples raw high.
REQ-016 Press requests SHALL be latched into a 7-bit pending register; at most one output pulse SHALL be asserted per cycle.
REQ-017 Pending priority SHALL be start > a > b > up > down > left > right; the granted bit clears in the same cycle its pulse is issued, and lower bits wait.
REQ-018 A new request for a bit already pending SHALL merge and not queue twice.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES in either direction SHALL produce no pulse and no state change beyond the debounce state.
REQ-020 Counters SHALL be sized by $clog2 of the largest parameter plus 1 and SHALL saturate, never wrap.
REQ-021 any_held SHALL be the OR of all buttons in HELD, REPEAT or RELEASE_DB.

Reset
REQ-022 While reset is low, all synchronizer flops, counters and pending bits SHALL be 0, all FSMs SHALL be in IDLE, and all outputs SHALL be 0.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL discard the event. After release, a button already held SHALL need a full debounce before it can pulse.

Structure
REQ-024 sudoku_pkg SHALL hold the button index constants, the debounce state enum and the default timing constants.
REQ-025 The per-button synchronizer, debounce and repeat logic SHALL be a sub-module named button_debouncer, instantiated 7 times with a REPEAT_EN parameter. Pending and arbitration logic stays in the top module.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3)
REQ-026 Hold raw start high from cycle 0 -> start_button high only in cycle 7; no further pulse while held; any_held falls 4 cycles after the synchronized low.
REQ-027 Toggle raw a high for 3 cycles then low -> no a_button pulse; FSM returns to IDLE.
REQ-028 Hold raw up for 30 cycles -> up_button pulses at cycle 7, then at 15, 18, 21, ... while held; hold raw a for 30 cycles -> exactly one pulse.
REQ-029 Raise raw start, a and down in the same cycle -> start_button, a_button and down_button each pulse once, in consecutive cycles 7, 8 and 9.
REQ-030 Assert reset low at cycle 5 of a held left press and release it at cycle 8, with the button still held -> no pulse before cycle 8+7; exactly one pulse after re-debounce.
